// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: payload layout, bubble constant and an entry-count helper.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_four;
        logic [31:0] instr;
    } if_id_payload_t;

    localparam int unsigned   IfIdW      = $bits(if_id_payload_t);
    localparam if_id_payload_t IfIdBubble = '0;

    function automatic logic [1:0] entry_count(input logic out_full, input logic skid_full);
        return {1'b0, out_full} + {1'b0, skid_full};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of pipe_stage_reg. empty_o is a flop output so the upstream ready
// never depends combinationally on the downstream ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IfIdW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              empty_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_empty;
    logic [DATA_W-1:0] r_data;

    // load only happens while empty and drain only while full, so they never collide.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_empty <= 1'b1;
        end else if (flush_i) begin
            r_empty <= 1'b1;
        end else if (load_i) begin
            r_empty <= 1'b0;
        end else if (drain_i) begin
            r_empty <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= data_i;
        end
    end

    assign empty_o = r_empty;
    assign data_o  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register. Define PIPE_SKID_EN for a two-entry skid stage with a
// registered in_ready_o; otherwise a single entry with combinational in_ready_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W     = IfIdW,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(IfIdBubble)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              w_out_valid_d;
    logic [DATA_W-1:0] w_out_data_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE_VAL;
        end else begin
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
        end
    end

`ifdef PIPE_SKID_EN
    logic              w_in_xfer;
    logic              w_skid_empty;
    logic              w_skid_load;
    logic              w_skid_drain;
    logic [DATA_W-1:0] w_skid_data;

    assign in_ready_o   = w_skid_empty;
    assign w_in_xfer    = in_valid_i && in_ready_o;
    assign w_skid_load  = w_in_xfer && r_out_valid && !out_ready_i;
    assign w_skid_drain = !w_skid_empty && out_ready_i;

    pipe_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (w_skid_load),
        .drain_i (w_skid_drain),
        .data_i  (in_data_i),
        .empty_o (w_skid_empty),
        .data_o  (w_skid_data)
    );

    // A full skid entry is always older than any new input, so it refills the output first.
    always_comb begin
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
        if (flush_i) begin
            w_out_valid_d = 1'b0;
            w_out_data_d  = BUBBLE_VAL;
        end else if (!w_skid_empty) begin
            if (out_ready_i) begin
                w_out_valid_d = 1'b1;
                w_out_data_d  = w_skid_data;
            end
        end else if (!r_out_valid || out_ready_i) begin
            w_out_valid_d = in_valid_i;
            w_out_data_d  = in_valid_i ? in_data_i : BUBBLE_VAL;
        end
    end

    assign count_o = entry_count(r_out_valid, !w_skid_empty);
`else
    assign in_ready_o = !r_out_valid || out_ready_i;

    always_comb begin
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
        if (flush_i) begin
            w_out_valid_d = 1'b0;
            w_out_data_d  = BUBBLE_VAL;
        end else if (in_ready_o) begin
            w_out_valid_d = in_valid_i;
            w_out_data_d  = in_valid_i ? in_data_i : BUBBLE_VAL;
        end
    end

    assign count_o = entry_count(r_out_valid, 1'b0);
`endif

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner sequences and a
// randomized run against a queue model of held entries.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

`ifdef PIPE_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif
    localparam logic [95:0] Bubble = '0;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [95:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [95:0] out_data_o;
    logic [1:0]  count_o;

    pipe_stage_reg u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        f;
        logic        iv;
        logic        orr;
        logic [95:0] d;
        logic        ev;
        logic [95:0] ed;
        logic [1:0]  ec;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [95:0] q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_ready(input logic orr);
        if (Cap == 2) return q.size() < 2;
        return (q.size() == 0) || orr;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {95'd0, out_valid_o}, {95'd0, q.size() > 0});
        check({tag, ".data"}, out_data_o, (q.size() > 0) ? q[0] : Bubble);
        check({tag, ".count"}, {94'd0, count_o}, 96'(q.size()));
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge and
    // return at the next falling edge.
    task automatic cycle(input logic f, input logic iv, input logic orr, input logic [95:0] d,
                         input bit full_chk);
        logic m_rdy;
        flush_i     = f;
        in_valid_i  = iv;
        out_ready_i = orr;
        in_data_i   = d;
        m_rdy       = model_ready(orr);
        #1;
        if (full_chk) check("in_ready", {95'd0, in_ready_o}, {95'd0, m_rdy});
        @(posedge clk_i);
        if (f) begin
            q.delete();
        end else begin
            if (q.size() > 0 && orr) q.delete(0);
            if (iv && m_rdy) q.push_back(d);
        end
        @(negedge clk_i);
        if (full_chk) check_model("step");
    endtask

    vec_t        tbl[9];
    int          n_xfer;
    logic [95:0] rnd;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 96'hA5, 1'b1, 96'hA5, 2'd1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 96'hB6, 1'b1, 96'hB6, 2'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 96'h00, 1'b0, 96'h00, 2'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 96'hC7, 1'b1, 96'hC7, 2'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 96'h00, 1'b1, 96'hC7, 2'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 96'h00, 1'b0, 96'h00, 2'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 96'hD8, 1'b1, 96'hD8, 2'd1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 96'hE9, 1'b0, 96'h00, 2'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 96'h00, 1'b0, 96'h00, 2'd0};

        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
        #1;
        check("rst.valid", {95'd0, out_valid_o}, 96'd0);
        check("rst.data", out_data_o, Bubble);
        check("rst.count", {94'd0, count_o}, 96'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rel.in_ready", {95'd0, in_ready_o}, 96'd1);

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].f, tbl[i].iv, tbl[i].orr, tbl[i].d, 1'b0);
            check($sformatf("vec%0d.valid", i), {95'd0, out_valid_o}, {95'd0, tbl[i].ev});
            check($sformatf("vec%0d.data", i), out_data_o, tbl[i].ed);
            check($sformatf("vec%0d.count", i), {94'd0, count_o}, {94'd0, tbl[i].ec});
        end

        // Stall for three cycles with continuous input.
        cycle(1'b0, 1'b1, 1'b0, 96'h11, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 96'h22, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 96'h33, 1'b1);
        check("stall.data", out_data_o, 96'h11);
        check("stall.count", {94'd0, count_o}, 96'(Cap));
        check("stall.in_ready", {95'd0, in_ready_o}, 96'd0);

        // Release: oldest first, then drain.
        cycle(1'b0, 1'b0, 1'b1, 96'h0, 1'b1);
`ifdef PIPE_SKID_EN
        check("drain1.data", out_data_o, 96'h22);
        check("drain1.count", {94'd0, count_o}, 96'd1);
`else
        check("drain1.data", out_data_o, Bubble);
        check("drain1.count", {94'd0, count_o}, 96'd0);
`endif
        cycle(1'b0, 1'b0, 1'b1, 96'h0, 1'b1);
        check("drain2.count", {94'd0, count_o}, 96'd0);

        // Flush with a full stage and a valid input in the flush cycle.
        cycle(1'b0, 1'b1, 1'b0, 96'h11, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 96'h22, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 96'h99, 1'b1);
        check("flush.valid", {95'd0, out_valid_o}, 96'd0);
        check("flush.data", out_data_o, Bubble);
        check("flush.count", {94'd0, count_o}, 96'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 96'h0, 1'b1);
            check("flush.no_ghost", {95'd0, out_valid_o}, 96'd0);
        end

        // Asynchronous reset between edges during a stall.
        cycle(1'b0, 1'b1, 1'b0, 96'h44, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 96'h55, 1'b1);
        #2;
        rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        check("arst.valid", {95'd0, out_valid_o}, 96'd0);
        check("arst.data", out_data_o, Bubble);
        check("arst.count", {94'd0, count_o}, 96'd0);
        q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("arst.in_ready", {95'd0, in_ready_o}, 96'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 96'h0, 1'b1);
            check("arst.no_stale", {95'd0, out_valid_o}, 96'd0);
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            cycle(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, rnd, 1'b1);
        end

        // Back-to-back throughput with downstream always ready.
        cycle(1'b1, 1'b0, 1'b1, 96'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 96'h1000, 1'b1);
        n_xfer = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 96'h2000 + 96'(i), 1'b1);
            if (out_valid_o) n_xfer++;
        end
        check("throughput", 96'(n_xfer), 96'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
